stream_rr_arbiter: RTL and testbench

Round-robin, packet-locked arbiter sharing one valid/ready stream channel between NUM_REQ requester streams. It sits in front of a single shared downstream sink (the DUT-side counterpart of the sequencer-to-driver channel), holds a grant from the first beat through the `last` beat, and registers the output through a two-entry skid buffer so the channel sustains one beat per cycle.

---
 rtl/stream_arb_pkg.sv | 28 ++
 rtl/stream_rr_arbiter_skid.sv | 50 +++++
 rtl/stream_rr_arbiter.sv | 101 ++++++++++
 tb/tb_stream_rr_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_pkg.sv
// Shared types and the round-robin pick function for the stream arbiter.
// The bench model calls rr_pick directly.
package stream_arb_pkg;

  localparam int MAX_REQ = 16;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  // First set bit of req scanning upward from (ptr+1) mod n; ptr when none.
  function automatic logic [3:0] rr_pick(
    input logic [15:0] req,
    input logic [3:0]  ptr,
    input int          n
  );
    int idx;
    rr_pick = ptr;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= n) begin
        idx = (int'(ptr) + k) % n;
        if (req[4'(idx)]) rr_pick = 4'(idx);
      end
    end
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_skid.sv
// Two-entry skid buffer that registers the arbiter output so the
// channel sustains one beat per cycle under backpressure.
module stream_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin, packet-locked arbiter: grants one requester from its
// first beat through its last beat into a shared output stream.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            s_valid,
  output logic [NUM_REQ-1:0]            s_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_REQ-1:0]            s_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_last,
  output logic [ID_WIDTH-1:0]           m_id,
  output logic                          busy
);

  localparam int PW = ID_WIDTH + 1 + DATA_WIDTH;

  arb_state_t            state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_q, grant_d;
  logic [ID_WIDTH-1:0]   rr_q, rr_d;
  logic [ID_WIDTH-1:0]   winner;
  logic                  locked;
  logic                  push_valid;
  logic                  buf_ready;
  logic                  accept;
  logic [DATA_WIDTH-1:0] data_sel;
  logic [PW-1:0]         buf_out;

  assign winner = ID_WIDTH'(rr_pick(16'(s_valid), 4'(rr_q), NUM_REQ));
  assign locked = (state_q == ARB_LOCKED);
  assign accept = push_valid && buf_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      rr_q    <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    case (state_q)
      ARB_IDLE: begin
        if (|s_valid) begin
          state_d = ARB_LOCKED;
          grant_d = winner;
        end
      end
      ARB_LOCKED: begin
        if (accept && s_last[grant_q]) begin
          state_d = ARB_IDLE;
          rr_d    = grant_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    busy       = locked;
    s_ready    = '0;
    push_valid = locked && s_valid[grant_q];
    data_sel   = '0;
    if (locked) s_ready[grant_q] = buf_ready;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_WIDTH'(i) == grant_q)
        data_sel = s_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  stream_skid_buf #(
    .W (PW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (push_valid),
    .in_ready  (buf_ready),
    .in_data   ({grant_q, s_last[grant_q], data_sel}),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_data  (buf_out)
  );

  assign {m_id, m_last, m_data} = buf_out;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scoreboard bench for stream_rr_arbiter: sources fed from queues,
// expected beats queued at stimulus time and compared at the output.
module tb_stream_rr_arbiter;
  import stream_arb_pkg::*;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic           clk;
  logic           rst;
  logic [NR-1:0]  s_valid;
  logic [NR-1:0]  s_ready;
  logic [NR*DW-1:0] s_data;
  logic [NR-1:0]  s_last;
  logic           m_valid;
  logic           m_ready;
  logic [DW-1:0]  m_data;
  logic           m_last;
  logic [IW-1:0]  m_id;
  logic           busy;

  stream_rr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .ID_WIDTH   (IW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .m_id    (m_id),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [32:0] src_q [NR][$];
  logic [34:0] exp_q [$];
  logic [NR-1:0] pause;
  logic [NR-1:0] acc;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int r, input int n, input int base,
                      input bit to_exp);
    logic lst;
    for (int k = 0; k < n; k++) begin
      lst = (k == n - 1);
      src_q[r].push_back({lst, 32'(base + k)});
      if (to_exp) exp_q.push_back({2'(r), lst, 32'(base + k)});
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    check(tag, exp_q.size(), 0);
  endtask

  // Source driver: retire accepted beats, then present each queue head.
  always begin
    logic [32:0] h;
    @(negedge clk);
    acc = s_valid & s_ready;
    @(posedge clk);
    #2;
    for (int i = 0; i < NR; i++)
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0 && !pause[i]) begin
        h = src_q[i][0];
        s_valid[i] = 1'b1;
        s_last[i]  = h[32];
        s_data[i*DW +: DW] = h[31:0];
      end else begin
        s_valid[i] = 1'b0;
      end
    end
  end

  // Output monitor against the scoreboard.
  always @(negedge clk) begin
    logic [34:0] e;
    if (!rst) begin
      check("onehot", 64'($onehot0(s_ready)), 1);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("beat", {m_id, m_last, m_data}, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt [NR];
    int sent [NR];
    logic [15:0] mask;
    logic [3:0] ptr;
    logic [3:0] w;

    rst = 1'b1;
    s_valid = '0;
    s_data = '0;
    s_last = '0;
    m_ready = 1'b1;
    pause = '0;
    #12;
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_id", m_id, 0);
    check("rst_busy", busy, 0);
    tick();
    rst = 1'b0;

    // Single requester, three beats.
    tick();
    send(2, 3, 'hA0, 1);
    tick();
    check("single_ready_c1", s_ready, 4'b0100);
    check("single_busy_c1", busy, 1);
    for (int c = 2; c <= 4; c++) begin
      tick();
      check("single_valid", m_valid, 1);
      check("single_id", m_id, 2);
      check("single_data", m_data, 32'hA0 + 32'(c - 2));
      check("single_last", m_last, (c == 4) ? 1 : 0);
    end
    tick();
    check("single_busy_c5", busy, 0);
    check("single_mvalid_c5", m_valid, 0);
    wait_drain("single_drain");

    // Fairness: everyone busy with single-beat packets.
    do_reset();
    tick();
    ptr = 4'd3;
    for (int i = 0; i < NR; i++) begin
      cnt[i] = 3;
      sent[i] = 0;
      for (int k = 0; k < 3; k++) send(i, 1, 'h100 + i * 16 + k, 0);
    end
    for (int b = 0; b < 12; b++) begin
      mask = '0;
      for (int i = 0; i < NR; i++) mask[i] = (cnt[i] > 0);
      w = rr_pick(mask, ptr, NR);
      exp_q.push_back({w[1:0], 1'b1, 32'('h100 + int'(w) * 16 + sent[w])});
      sent[w]++;
      cnt[w]--;
      ptr = w;
    end
    for (int c = 1; c <= 24; c++) begin
      tick();
      check("fair_gap", (s_ready != 0), c % 2);
    end
    wait_drain("fair_drain");

    // Lock hold across a mid-packet valid drop.
    do_reset();
    tick();
    send(1, 4, 'h10, 1);
    tick();
    check("lock_ready_c1", s_ready, 4'b0010);
    send(0, 1, 'h0F, 1);
    tick();
    pause[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check("lock_no_r0", s_ready[0], 0);
      check("lock_busy", busy, 1);
      tick();
    end
    pause[1] = 1'b0;
    wait_drain("lock_drain");

    // Backpressure: two beats land, then the channel stalls.
    do_reset();
    tick();
    m_ready = 1'b0;
    send(2, 6, 'h60, 1);
    tick();
    tick();
    tick();
    check("bp_stall_c3", s_ready, 0);
    tick();
    check("bp_stall_c4", s_ready, 0);
    check("bp_accepted", src_q[2].size(), 4);
    check("bp_held", m_data, 32'h60);
    tick();
    m_ready = 1'b1;
    check("bp_stall_c5", s_ready, 0);
    tick();
    check("bp_resume_c6", s_ready, 4'b0100);
    wait_drain("bp_drain");

    // Reset in the middle of a packet discards it.
    do_reset();
    tick();
    m_ready = 1'b0;
    send(1, 4, 'h40, 0);
    tick();
    tick();
    tick();
    check("mid_full", s_ready, 0);
    check("mid_valid", m_valid, 1);
    src_q[1].delete();
    rst = 1'b1;
    #1;
    check("mid_rst_mvalid", m_valid, 0);
    check("mid_rst_sready", s_ready, 0);
    check("mid_rst_busy", busy, 0);
    m_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    send(3, 2, 'h30, 1);
    tick();
    check("post_rst_ready", s_ready, 4'b1000);
    wait_drain("post_rst_drain");
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
